ysyx_lsu: RTL and testbench
===========================

# ysyx_lsu

Load/store unit sitting between the execute stage and the data-memory bus. It consumes the decoder's memory controls (`dm_rd_sel`, `dm_wr_sel`), the ALU-computed address and the store data. It performs one word-aligned bus transaction per instruction with byte-lane masking, then returns sign- or zero-extended load data to write-back over a valid/ready handshake. Misaligned and illegal control combinations are flagged without touching the bus.

## Interface
- No parameters; data and address width are fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request from execute stage.
- `in_ready`  out  1  LSU can accept; high only in IDLE.
- `in_addr`  in  32  byte address (ALU result).
- `in_wdata`  in  32  store source (rs2).
- `in_rd_sel`  in  3  load type, decoder encoding:
  - 000 none; 001 lb; 010 lbu; 011 lh; 100 lhu; 101 lw; 110/111 reserved.
- `in_wr_sel`  in  2  store type: 00 none; 01 sb; 10 sh; 11 sw.
- `mem_req_valid`  out  1  bus request.
- `mem_req_ready`  in  1  bus accepts request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  `{in_addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wmask`  out  4  byte enables; 0000 on reads.
- `mem_rsp_valid`  in  1  read data / write ack, one-cycle pulse.
- `mem_rdata`  in  32  read word.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  write-back accepts.
- `out_rdata`  out  32  extended load data; 0 for stores, none and error.
- `out_err`  out  1  misaligned or illegal op.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - REQ: `mem_req_valid`=1.
  - WAIT: awaiting `mem_rsp_valid`.
  - DONE: `out_valid`=1.
- IDLE, accept on `in_valid && in_ready`. Capture `addr`, `wdata`, `rd_sel`, `wr_sel` into registers; all later outputs derive from these captured values.
  - Legal memory op: go to REQ.
  - Both sels zero: go to DONE with `out_rdata`=0, `out_err`=0, no bus access.
  - Error: go to DONE with `out_err`=1, `out_rdata`=0, no bus access. Error cases:
    - both sels nonzero;
    - `rd_sel` is 110 or 111;
    - halfword access with `addr[0]`=1;
    - word access with `addr[1:0]`≠0.
- REQ: hold `mem_req_valid`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wmask` stable until `mem_req_ready`; then go to WAIT.
- WAIT: on `mem_rsp_valid`, register the extended result and go to DONE. `mem_rsp_valid` is ignored in every other state.
- DONE: hold `out_valid`, `out_rdata` and `out_err` until `out_ready`; then go to IDLE.
- Store lanes, with `o = addr[1:0]`:
  - sb: mask `4'b0001<<o`, data `{4{wdata[7:0]}}`.
  - sh: mask `4'b0011<<o`, data `{2{wdata[15:0]}}`.
  - sw: mask `1111`, data `wdata`.
- Load extract: `b = mem_rdata >> (8*o)`.
  - lb: sign-extend `b[7:0]`.
  - lbu: zero-extend `b[7:0]`.
  - lh: sign-extend `b[15:0]`.
  - lhu: zero-extend `b[15:0]`.
  - lw: `mem_rdata`.

## Timing
- Reset values: state IDLE; `in_ready`=1; all other outputs 0, including `mem_*` outputs, `out_rdata` and `out_err`.
- Cycle numbering: accept at T.
  - `mem_req_valid` rises at T+1.
  - With `mem_req_ready` at T+1 and `mem_rsp_valid` at T+2, `out_valid` is high at T+3.
  - Each stall cycle of ready or response adds one cycle.
- Non-memory op or error: `out_valid` at T+1.
- `in_ready` falls the cycle after accept; at most one instruction is in flight.
- Back-to-back operation: `out_ready` at cycle D returns to IDLE at D+1, so the next accept is possible at D+1.
- The bus never returns a response in the same cycle as its request handshake. A response in REQ is a protocol violation and is ignored.
- `rst_n` low at any time:
  - state and outputs immediately take their reset values;
  - an outstanding request is abandoned;
  - a late response arriving after reset release is ignored, because the FSM is in IDLE.
- Inputs change while not in IDLE: no effect.

## Test plan
- lb from `in_addr`=0x8000_0003, `mem_rdata`=0x80FF_1234 -> `mem_addr`=0x8000_0000, `mem_wmask`=0000, `out_rdata`=0xFFFF_FF80, `out_err`=0; `out_valid` at T+3 with zero-wait bus.
- lhu from 0x8000_0002, rdata 0xBEEF_0001 -> `out_rdata`=0x0000_BEEF.
- lh from 0x8000_0002, same rdata -> `out_rdata`=0xFFFF_BEEF.
- sb `in_wdata`=0x1234_56AB at 0x8000_0001 -> `mem_we`=1, `mem_wmask`=0010, `mem_wdata`=0xABAB_ABAB, `out_rdata`=0.
- sw at 0x8000_0000 with `mem_req_ready` held low 3 cycles -> request fields stable for all 4 request cycles; `out_valid` at T+6.
- lw at 0x8000_0002 -> `out_err`=1 at T+1, `mem_req_valid` never asserted.
- `rd_sel`=001 with `wr_sel`=01 -> `out_err`=1 at T+1.
- `out_ready` held low 5 cycles in DONE -> `out_valid` and `out_rdata` hold; `in_ready`=0 throughout.
- `rst_n` pulsed low in WAIT, then `mem_rsp_valid` pulsed after release -> outputs at reset values, `out_valid` stays 0.

Source files
------------

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit between execute and the data-memory bus.
// One word-aligned bus transaction per instruction, byte-lane masked stores,
// sign/zero-extended loads, and error reporting for misaligned or illegal
// control combinations without any bus activity.
module ysyx_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_rd_sel,
  input  logic [1:0]  in_wr_sel,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic        in_ready_r;
  logic        mem_req_valid_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;
  logic        out_valid_r;
  logic [31:0] out_rdata_r;
  logic        out_err_r;
  logic [2:0]  rd_sel_r;
  logic [1:0]  off_r;

  logic        accept_s;
  logic        is_none_s;
  logic        is_err_s;
  logic        is_half_s;
  logic        is_word_s;
  logic [3:0]  lane_mask_s;
  logic [31:0] lane_data_s;

  // Extract the addressed byte/halfword from the bus word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0]  sel,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [31:0] b;
    b = word >> {off, 3'b000};
    case (sel)
      3'b001:  load_extend = {{24{b[7]}}, b[7:0]};
      3'b010:  load_extend = {24'd0, b[7:0]};
      3'b011:  load_extend = {{16{b[15]}}, b[15:0]};
      3'b100:  load_extend = {16'd0, b[15:0]};
      3'b101:  load_extend = word;
      default: load_extend = 32'd0;
    endcase
  endfunction

  assign accept_s = in_valid && in_ready_r;

  // Classify the incoming request: no-op, error, and access size.
  always_comb begin
    is_none_s = (in_rd_sel == 3'b000) && (in_wr_sel == 2'b00);
    is_half_s = (in_rd_sel == 3'b011) || (in_rd_sel == 3'b100) || (in_wr_sel == 2'b10);
    is_word_s = (in_rd_sel == 3'b101) || (in_wr_sel == 2'b11);
    is_err_s  = ((in_rd_sel != 3'b000) && (in_wr_sel != 2'b00))
              || (in_rd_sel[2:1] == 2'b11)
              || (is_half_s && in_addr[0])
              || (is_word_s && (in_addr[1:0] != 2'b00));
  end

  // Build the store byte enables and lane-replicated store data.
  always_comb begin
    lane_mask_s = 4'b0000;
    lane_data_s = 32'd0;
    case (in_wr_sel)
      2'b01: begin
        lane_mask_s = 4'b0001 << in_addr[1:0];
        lane_data_s = {4{in_wdata[7:0]}};
      end
      2'b10: begin
        lane_mask_s = 4'b0011 << in_addr[1:0];
        lane_data_s = {2{in_wdata[15:0]}};
      end
      2'b11: begin
        lane_mask_s = 4'b1111;
        lane_data_s = in_wdata;
      end
      default: begin
        lane_mask_s = 4'b0000;
        lane_data_s = 32'd0;
      end
    endcase
  end

  // Next-state logic for the request/response sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_err_s || is_none_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered handshake flags, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r      <= 1'b1;
      mem_req_valid_r <= 1'b0;
      out_valid_r     <= 1'b0;
    end else begin
      in_ready_r      <= (state_nxt_s == ST_IDLE);
      mem_req_valid_r <= (state_nxt_s == ST_REQ);
      out_valid_r     <= (state_nxt_s == ST_DONE);
    end
  end

  // Capture the request on accept and the extended load result on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wmask_r <= 4'b0000;
      out_rdata_r <= 32'd0;
      out_err_r   <= 1'b0;
      rd_sel_r    <= 3'b000;
      off_r       <= 2'b00;
    end else if (accept_s) begin
      // Bus fields are only loaded for a real access so that no-op and
      // error requests leave the bus side quiet.
      if (is_err_s || is_none_s) begin
        mem_we_r    <= 1'b0;
        mem_addr_r  <= 32'd0;
        mem_wdata_r <= 32'd0;
        mem_wmask_r <= 4'b0000;
      end else begin
        mem_we_r    <= (in_wr_sel != 2'b00);
        mem_addr_r  <= {in_addr[31:2], 2'b00};
        mem_wdata_r <= lane_data_s;
        mem_wmask_r <= lane_mask_s;
      end
      out_rdata_r <= 32'd0;
      out_err_r   <= is_err_s;
      rd_sel_r    <= in_rd_sel;
      off_r       <= in_addr[1:0];
    end else if ((state_r == ST_WAIT) && mem_rsp_valid) begin
      // Stores carry rd_sel 000, so their result extends to zero.
      out_rdata_r <= load_extend(rd_sel_r, off_r, mem_rdata);
    end else begin
      out_rdata_r <= out_rdata_r;
    end
  end

  assign in_ready      = in_ready_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign mem_wmask     = mem_wmask_r;
  assign out_valid     = out_valid_r;
  assign out_rdata     = out_rdata_r;
  assign out_err       = out_err_r;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed self-checking bench for ysyx_lsu.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_rd_sel;
  logic [1:0]  in_wr_sel;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd_sel(in_rd_sel), .in_wr_sel(in_wr_sel),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full bus transaction: accept, REQ (with stall cycles), WAIT, DONE (with hold cycles).
  task automatic mem_op(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int stall,
                        input logic exp_we, input logic [31:0] exp_addr,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input int hold);
    in_valid = 1'b1; in_rd_sel = rd; in_wr_sel = wr; in_addr = addr; in_wdata = wdata;
    chk({tag, ".in_ready_idle"}, in_ready, 32'd1);
    tick();
    // Garbage on the inputs while busy must have no effect.
    in_valid = 1'b0; in_addr = 32'hDEAD_BEEF; in_wdata = 32'h0BAD_F00D;
    in_rd_sel = 3'b101; in_wr_sel = 2'b11;
    for (int i = 0; i <= stall; i++) begin
      chk({tag, ".req_valid"}, mem_req_valid, 32'd1);
      chk({tag, ".in_ready_busy"}, in_ready, 32'd0);
      chk({tag, ".we"}, mem_we, exp_we);
      chk({tag, ".addr"}, mem_addr, exp_addr);
      chk({tag, ".mask"}, mem_wmask, exp_mask);
      chk({tag, ".wdata"}, mem_wdata, exp_wdata);
      if (i == stall) begin
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      end else begin
        // Response during REQ is a protocol violation and must be ignored.
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
      end
      tick();
    end
    mem_req_ready = 1'b0;
    chk({tag, ".wait_req_low"}, mem_req_valid, 32'd0);
    chk({tag, ".wait_out_low"}, out_valid, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0; mem_rdata = 32'h1357_9BDF;
    for (int j = 0; j <= hold; j++) begin
      chk({tag, ".out_valid"}, out_valid, 32'd1);
      chk({tag, ".out_rdata"}, out_rdata, exp_rdata);
      chk({tag, ".out_err"}, out_err, 32'd0);
      chk({tag, ".in_ready_done"}, in_ready, 32'd0);
      out_ready = (j == hold);
      tick();
    end
    out_ready = 1'b0;
    chk({tag, ".back_idle"}, in_ready, 32'd1);
    chk({tag, ".out_drop"}, out_valid, 32'd0);
  endtask

  // No-op or error request: result at T+1 with no bus activity.
  task automatic fast_op(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                         input logic [31:0] addr, input logic exp_err);
    in_valid = 1'b1; in_rd_sel = rd; in_wr_sel = wr; in_addr = addr; in_wdata = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    chk({tag, ".out_valid"}, out_valid, 32'd1);
    chk({tag, ".out_err"}, out_err, exp_err);
    chk({tag, ".out_rdata"}, out_rdata, 32'd0);
    chk({tag, ".no_req"}, mem_req_valid, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".no_req_after"}, mem_req_valid, 32'd0);
    chk({tag, ".back_idle"}, in_ready, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = 32'd0; in_wdata = 32'd0;
    in_rd_sel = 3'b000; in_wr_sel = 2'b00; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
    tick(); tick();
    chk("rst.in_ready", in_ready, 32'd1);
    chk("rst.req_valid", mem_req_valid, 32'd0);
    chk("rst.out_valid", out_valid, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.out_rdata", out_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    //      tag    rd      wr     addr           wdata          rdata        stl we    addr           mask     wdata          result         hold
    mem_op("lb",  3'b001, 2'b00, 32'h8000_0003, 32'd0,         32'h80FF_1234, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'd0,         32'hFFFF_FF80, 0);
    mem_op("lhu", 3'b100, 2'b00, 32'h8000_0002, 32'd0,         32'hBEEF_0001, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'd0,         32'h0000_BEEF, 0);
    mem_op("lh",  3'b011, 2'b00, 32'h8000_0002, 32'd0,         32'hBEEF_0001, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'd0,         32'hFFFF_BEEF, 5);
    mem_op("lbu", 3'b010, 2'b00, 32'h8000_0001, 32'd0,         32'h1234_F678, 1, 1'b0, 32'h8000_0000, 4'b0000, 32'd0,         32'h0000_00F6, 0);
    mem_op("lw",  3'b101, 2'b00, 32'h8000_0004, 32'd0,         32'hCAFE_BABE, 0, 1'b0, 32'h8000_0004, 4'b0000, 32'd0,         32'hCAFE_BABE, 0);
    mem_op("sb",  3'b000, 2'b01, 32'h8000_0001, 32'h1234_56AB, 32'h5555_5555, 0, 1'b1, 32'h8000_0000, 4'b0010, 32'hABAB_ABAB, 32'd0,         0);
    mem_op("sh",  3'b000, 2'b10, 32'h8000_0002, 32'h0000_BEEF, 32'h5555_5555, 0, 1'b1, 32'h8000_0000, 4'b1100, 32'hBEEF_BEEF, 32'd0,         0);
    mem_op("sw",  3'b000, 2'b11, 32'h8000_0000, 32'h89AB_CDEF, 32'h5555_5555, 3, 1'b1, 32'h8000_0000, 4'b1111, 32'h89AB_CDEF, 32'd0,         0);

    fast_op("lw_misal",  3'b101, 2'b00, 32'h8000_0002, 1'b1);
    fast_op("ld_and_st", 3'b001, 2'b01, 32'h8000_0000, 1'b1);
    fast_op("rd_rsvd",   3'b110, 2'b00, 32'h8000_0000, 1'b1);
    fast_op("sh_misal",  3'b000, 2'b10, 32'h8000_0001, 1'b1);
    fast_op("none",      3'b000, 2'b00, 32'h8000_0003, 1'b0);

    // Reset during WAIT, then a stale response after release.
    in_valid = 1'b1; in_rd_sel = 3'b101; in_wr_sel = 2'b00; in_addr = 32'h8000_0008;
    tick();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rstw.in_wait", mem_req_valid, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstw.in_ready", in_ready, 32'd1);
    chk("rstw.req_valid", mem_req_valid, 32'd0);
    chk("rstw.mem_addr", mem_addr, 32'd0);
    chk("rstw.out_valid", out_valid, 32'd0);
    chk("rstw.out_rdata", out_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rstw.late_out_valid", out_valid, 32'd0);
    chk("rstw.late_out_rdata", out_rdata, 32'd0);
    tick();
    chk("rstw.still_idle", in_ready, 32'd1);
    chk("rstw.still_no_out", out_valid, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
